// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART receiver, transmitter and their byte buffers.
//   UART_DATA_W        : character width carried between receiver/transmitter
//                        and the FIFOs.
//   UART_RX_FIFO_DEPTH : default number of entries in the receive buffer.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

endpackage : uart_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Generic single-clock first-word-fall-through FIFO. It is reusable for both
// the receive and the transmit direction.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   wr_en    in   write strobe. It is always honoured, so the caller must not
//                 assert it while full unless a pop happens on the same edge.
//   wr_data  in   DATA_W word to store
//   rd_en    in   pop request. It is ignored while empty.
//   rd_data  out  head-of-FIFO word. It is valid while empty=0.
//   count    out  ADDR_W+1 bits, number of stored words (0..DEPTH)
//   empty    out  count == 0
//   full     out  count == DEPTH
// -----------------------------------------------------------------------------
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_pop;

    assign do_pop = rd_en & ~empty;

    // NOTE: storage has no reset. Entries are only read after they have been
    // written, so clearing them would add reset fan-out without changing
    // behaviour.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the natural ADDR_W-bit rollover gives the
    // modulo-DEPTH pointer wrap. count is what separates full from empty when
    // the pointers are equal.
    // NOTE: all state in clocked blocks uses non-blocking assignments, so
    // every register samples the values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive byte buffer placed directly after the UART receiver. It turns each
// rx_done pulse into exactly one push, stores the bytes in a sync_fifo, and
// keeps a sticky flag for bytes lost to overflow.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high
//   rx_data       in   DATA_W byte from the receiver, valid while rx_done=1
//   rx_done       in   receiver completion flag. It may stay high for several
//                      cycles and still gives one byte per rising edge.
//   rd_en         in   pop request. The head is consumed when empty=0.
//   clr_overflow  in   clears the sticky overflow flag
//   rd_data       out  head-of-FIFO byte (first-word-fall-through)
//   empty         out  no entries stored
//   full          out  DEPTH entries stored
//   count         out  ADDR_W+1 bits, stored entries (0..DEPTH)
//   overflow      out  sticky, set when a byte was dropped because the FIFO
//                      was full
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = UART_RX_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_done,
    input  logic              rd_en,
    input  logic              clr_overflow,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    logic rx_done_q;
    logic push;
    logic pop;
    logic push_ok;
    logic push_drop;

    // rx_done_q is cleared by reset. If rx_done is already high when reset
    // releases, the first edge is therefore treated as a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_q <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
        end
    end

    assign push = rx_done & ~rx_done_q;
    assign pop  = rd_en & ~empty;

    // When the FIFO is full, a push is still accepted if the head leaves on
    // the same edge. count stays at DEPTH and no byte is lost.
    assign push_ok   = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    // When a drop and a clear land on the same edge, the drop wins, so a new
    // loss is never hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_ok),
        .wr_data (rx_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

endmodule : uart_rx_fifo
